// File: rtl/flop_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flop_chk_pkg
//  Description : Shared types for the flop response checker: FSM state
//                encoding and the delay-line entry carried from vector
//                accept to compare.
//  Revision    : 1.0 - initial release
// ============================================================================
package flop_chk_pkg;

  // Data width of the DUT q and of the expected value.
  localparam int W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic         vld;
    logic         last;
    logic [W-1:0] exp;
  } chk_entry_t;

endpackage
`default_nettype wire

// File: rtl/flop_resp_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : flop_resp_checker_if
//  Description : Stimulus/response bundle between the flop stimulus side
//                (master) and the response checker (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface flop_resp_checker_if #(
  parameter int CNT_W = 16
);
  import flop_chk_pkg::*;

  logic             start;
  logic             vec_valid;
  logic [W-1:0]     vec_exp;
  logic             vec_last;
  logic [W-1:0]     dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic             first_err_vld;

  modport master (
    output start, vec_valid, vec_exp, vec_last, dut_q,
    input  busy, done, pass, vec_count, err_count, first_err_idx, first_err_vld
  );

  modport slave (
    input  start, vec_valid, vec_exp, vec_last, dut_q,
    output busy, done, pass, vec_count, err_count, first_err_idx, first_err_vld
  );

endinterface
`default_nettype wire

// File: rtl/chk_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : chk_delay_line
//  Description : LATENCY-stage shift register of chk_entry_t. Aligns each
//                expected value with the DUT q it must be compared to.
//  Revision    : 1.0 - initial release
// ============================================================================
module chk_delay_line
  import flop_chk_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  chk_entry_t din,
  output chk_entry_t tail
);

  chk_entry_t r_stages [LATENCY];

  // Shift every cycle; clear drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) r_stages[i] <= '0;
    end else begin
      r_stages[0] <= din;
      for (int i = 1; i < LATENCY; i++) r_stages[i] <= r_stages[i-1];
    end
  end

  assign tail = r_stages[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/flop_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : flop_resp_checker
//  Description : Response checker for a flop DUT. Delays each accepted
//                expected value by LATENCY cycles, compares it with dut_q,
//                counts vectors and mismatches, and reports pass/fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module flop_resp_checker
  import flop_chk_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  flop_resp_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  chk_state_t r_state;
  chk_entry_t w_push;
  chk_entry_t w_tail;
  logic       w_start_go;
  logic       w_accept;
  logic       w_compare;
  logic       w_mismatch;

  // start only takes effect from IDLE or DONE.
  assign w_start_go = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_accept   = bus.vec_valid && (r_state == RUN);
  assign w_push     = '{vld: w_accept, last: bus.vec_last, exp: bus.vec_exp};
  assign w_compare  = w_tail.vld;
  // Case inequality so an X/Z on either side counts as a mismatch in sim.
  assign w_mismatch = (w_tail.exp !== bus.dut_q);

  chk_delay_line #(.LATENCY(LATENCY)) u_delay (
    .clk  (clk),
    .clr  (reset),
    .din  (w_push),
    .tail (w_tail)
  );

  // Run-control FSM with registered busy/done/pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else if (w_start_go) begin
      r_state  <= RUN;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept && bus.vec_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_compare && w_tail.last) begin
            r_state  <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            // Include the final compare, whose error is not yet counted.
            bus.pass <= (bus.err_count == '0) && !w_mismatch;
          end
        end
        default: ;
      endcase
    end
  end

  // Vector/error counters and first-error capture; start discards a same-cycle compare.
  always_ff @(posedge clk) begin
    if (reset || w_start_go) begin
      bus.vec_count     <= '0;
      bus.err_count     <= '0;
      bus.first_err_idx <= '0;
      bus.first_err_vld <= 1'b0;
    end else if (w_compare) begin
      bus.vec_count <= bus.vec_count + c_one;
      if (w_mismatch) begin
        if (bus.err_count != '1) bus.err_count <= bus.err_count + c_one;
        if (!bus.first_err_vld) begin
          bus.first_err_idx <= bus.vec_count;
          bus.first_err_vld <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flop_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flop_resp_checker
//  Description : Self-checking bench for flop_resp_checker. Instance A uses
//                LATENCY=1 with narrow counters; instance B uses LATENCY=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_resp_checker;
  import flop_chk_pkg::*;

  localparam int CW_A = 4;
  localparam int CW_B = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  flop_resp_checker_if #(.CNT_W(CW_A)) bus_a ();
  flop_resp_checker_if #(.CNT_W(CW_B)) bus_b ();

  flop_resp_checker #(.LATENCY(1), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  flop_resp_checker #(.LATENCY(3), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Stand-in flop DUTs: the bench chooses what q each will produce.
  logic [W-1:0] qd_a;
  logic [W-1:0] qd_b;
  logic [W-1:0] pb [3];

  always_ff @(posedge clk) bus_a.dut_q <= qd_a;

  always_ff @(posedge clk) begin
    pb[0] <= qd_b;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign bus_b.dut_q = pb[2];

  // Scoreboard for instance A.
  typedef struct {
    int              due;
    logic [CW_A-1:0] vc;
    logic [CW_A-1:0] ec;
    logic [CW_A-1:0] fi;
    logic            fv;
  } exp_t;

  exp_t            sb[$];
  logic [CW_A-1:0] m_vc, m_ec, m_fi;
  logic            m_fv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t r;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      r = sb.pop_front();
      chk("sb_vec_count",     32'(bus_a.vec_count),     32'(r.vc));
      chk("sb_err_count",     32'(bus_a.err_count),     32'(r.ec));
      chk("sb_first_err_idx", 32'(bus_a.first_err_idx), 32'(r.fi));
      chk("sb_first_err_vld", 32'(bus_a.first_err_vld), 32'(r.fv));
    end
  endtask

  task automatic model_clear();
    m_vc = '0; m_ec = '0; m_fi = '0; m_fv = 1'b0;
    sb.delete();
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    model_clear();
    step();
    bus_a.start = 1'b0;
  endtask

  // Drive one vector on A (accepted in RUN); st drives start alongside.
  task automatic vec(input logic [W-1:0] e, input logic [W-1:0] q, input logic last,
                     input logic st = 1'b0);
    logic mm;
    bus_a.vec_valid = 1'b1;
    bus_a.vec_exp   = e;
    bus_a.vec_last  = last;
    bus_a.start     = st;
    qd_a            = q;
    mm = (q !== e);
    if (mm) begin
      if (m_ec != '1) m_ec = m_ec + 1'b1;
      if (!m_fv) begin m_fi = m_vc; m_fv = 1'b1; end
    end
    m_vc = m_vc + 1'b1;
    sb.push_back('{due: cyc + 2, vc: m_vc, ec: m_ec, fi: m_fi, fv: m_fv});
    step();
    bus_a.vec_valid = 1'b0;
    bus_a.vec_last  = 1'b0;
    bus_a.start     = 1'b0;
  endtask

  task automatic chk_flags_a(input string tag, input logic busy, input logic done,
                             input logic pass);
    chk({tag, "_busy"}, 32'(bus_a.busy), 32'(busy));
    chk({tag, "_done"}, 32'(bus_a.done), 32'(done));
    chk({tag, "_pass"}, 32'(bus_a.pass), 32'(pass));
  endtask

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.vec_valid = 1'b1; bus_a.vec_exp = '0; bus_a.vec_last = 1'b0;
    bus_b.start = 1'b0; bus_b.vec_valid = 1'b0; bus_b.vec_exp = '0; bus_b.vec_last = 1'b0;
    qd_a = '0; qd_b = '0;
    model_clear();

    // Reset for two cycles with vec_valid asserted; everything stays zero.
    step();
    step();
    chk_flags_a("rst_a", 1'b0, 1'b0, 1'b0);
    chk("rst_vec_count", 32'(bus_a.vec_count), 32'd0);
    chk("rst_err_count", 32'(bus_a.err_count), 32'd0);
    chk("rst_first_idx", 32'(bus_a.first_err_idx), 32'd0);
    chk("rst_first_vld", 32'(bus_a.first_err_vld), 32'd0);
    chk("rst_b_busy",    32'(bus_b.busy), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_vec_dropped", 32'(bus_a.vec_count), 32'd0);
    chk("idle_busy",        32'(bus_a.busy), 32'd0);
    bus_a.vec_valid = 1'b0;

    // Clean run: 0,1,1,0 all matching.
    start_a();
    chk_flags_a("run1_started", 1'b1, 1'b0, 1'b0);
    vec(1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 1'b0);
    vec(1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 1'b1);
    chk_flags_a("run1_drain", 1'b1, 1'b0, 1'b0);
    step();
    chk_flags_a("run1_done", 1'b0, 1'b1, 1'b1);
    chk("run1_vec_count", 32'(bus_a.vec_count), 32'd4);
    step();
    chk_flags_a("run1_hold", 1'b0, 1'b1, 1'b1);

    // Same run with q=0 on vector index 1.
    start_a();
    chk_flags_a("run2_restart", 1'b1, 1'b0, 1'b0);
    vec(1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 1'b1);
    step();
    chk_flags_a("run2_done", 1'b0, 1'b1, 1'b0);
    chk("run2_err_count", 32'(bus_a.err_count), 32'd1);
    chk("run2_first_idx", 32'(bus_a.first_err_idx), 32'd1);

    // X on q, then enough mismatches to saturate the 4-bit error counter.
    start_a();
    vec(1'b1, 1'bx, 1'b0);
    for (int i = 0; i < 17; i++) vec(1'b0, 1'b1, (i == 16));
    step();
    chk_flags_a("run3_done", 1'b0, 1'b1, 1'b0);
    chk("run3_err_sat",   32'(bus_a.err_count), 32'hF);
    chk("run3_vec_wrap",  32'(bus_a.vec_count), 32'd2);

    // start while in RUN is ignored: counters keep counting.
    start_a();
    vec(1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 1'b0, 1'b1);
    vec(1'b1, 1'b0, 1'b1);
    step();
    chk_flags_a("run4_done", 1'b0, 1'b1, 1'b0);
    chk("run4_vec_count", 32'(bus_a.vec_count), 32'd3);
    chk("run4_first_idx", 32'(bus_a.first_err_idx), 32'd2);

    // Reset during DRAIN aborts; the pending compare is discarded.
    start_a();
    vec(1'b0, 1'b0, 1'b0);
    vec(1'b1, 1'b0, 1'b1);
    chk_flags_a("run5_drain", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    model_clear();
    step();
    reset = 1'b0;
    chk_flags_a("run5_reset", 1'b0, 1'b0, 1'b0);
    chk("run5_vec_count", 32'(bus_a.vec_count), 32'd0);
    chk("run5_err_count", 32'(bus_a.err_count), 32'd0);
    step();
    chk("run5_no_late_cmp", 32'(bus_a.vec_count), 32'd0);
    start_a();
    vec(1'b1, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 1'b1);
    step();
    chk_flags_a("run6_done", 1'b0, 1'b1, 1'b1);
    chk("run6_vec_count", 32'(bus_a.vec_count), 32'd2);

    // Instance B, LATENCY=3: single vector tagged last.
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    chk("b_run_busy", 32'(bus_b.busy), 32'd1);
    bus_b.vec_valid = 1'b1; bus_b.vec_exp = 1'b1; bus_b.vec_last = 1'b1; qd_b = 1'b1;
    step();
    bus_b.vec_valid = 1'b0; bus_b.vec_last = 1'b0; qd_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_drain_busy", 32'(bus_b.busy), 32'd1);
      chk("b_drain_done", 32'(bus_b.done), 32'd0);
      step();
    end
    chk("b_done",      32'(bus_b.done), 32'd1);
    chk("b_busy_off",  32'(bus_b.busy), 32'd0);
    chk("b_pass",      32'(bus_b.pass), 32'd1);
    chk("b_vec_count", 32'(bus_b.vec_count), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
